// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_valid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order requests to a variable-latency memory,
// a small response FIFO, and a bubble-on-empty pc/inst pair for IF/ID.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         hazard_i,
   input  logic         flush_i,
   input  logic [31:0]  target_i,
   fetch_unit_if.master imem,
   output logic [31:0]  pc_o,
   output logic [31:0]  inst_o,
   output logic         valid_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
   logic [31:0]      r_fifo_inst [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [OUT_W-1:0] r_outstanding;
   logic [OUT_W-1:0] r_drop_cnt;
   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_resp_pc;

   logic w_credit;
   logic w_req;
   logic w_accept;
   logic w_resp;
   logic w_drop;
   logic w_push;
   logic w_valid;
   logic w_pop;

   // Credit: every accepted request already owns a FIFO slot, so responses
   // never need back-pressure.
   assign w_credit = ((32'(r_outstanding) + 32'(r_count)) < 32'(FIFO_DEPTH)) &&
                     (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
   assign w_req    = !rst_i && !flush_i && w_credit;
   assign w_accept = w_req && imem.imem_ready;

   // Stray responses with nothing outstanding (e.g. pre-reset requests) are ignored.
   assign w_resp   = imem.imem_valid && (r_outstanding != '0);
   assign w_drop   = w_resp && (r_drop_cnt != '0);
   assign w_push   = w_resp && !w_drop && !flush_i;

   assign w_valid  = (r_count != '0) && !rst_i;
   assign w_pop    = w_valid && !hazard_i && !flush_i;

   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_fetch_pc;

   assign valid_o = w_valid;
   assign pc_o    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
   assign inst_o  = w_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= r_outstanding + OUT_W'(w_accept) - OUT_W'(w_resp);
         if (flush_i) begin
            r_fetch_pc <= target_i;
            r_resp_pc  <= target_i;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // Everything still unreturned after this cycle belongs to the old path.
            r_drop_cnt <= r_outstanding - OUT_W'(w_resp);
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_drop) begin
               r_drop_cnt <= r_drop_cnt - OUT_W'(1);
            end
            if (w_push) begin
               r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
               r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
         r_fifo_inst[r_wr_ptr] <= imem.imem_rdata;
      end
   end

endmodule
